mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Owns the single byte-wide synchronous RAM port and shares it between two requesters:
//  instruction fetch (IF) and the load/store stage (MEM).
//  Serialises each 1/2/4-byte access into consecutive byte cycles, little-endian.
//  Assembles read bytes into a 32-bit word; fetched words feed if_id and then the decoder.
// PARAMETERS
//  ADDR_W  17  RAM address width; request addresses are truncated to ADDR_W bits
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       asynchronous active-low reset
//  if_req_i     in   1       IF fetch request, held until if_done_o
//  if_addr_i    in   32      fetch address (always a 4-byte read)
//  if_flush_i   in   1       abandon any pending/in-flight fetch (branch redirect)
//  if_done_o    out  1       1-cycle pulse: if_inst_o valid
//  if_inst_o    out  32      fetched instruction
//  mem_req_i    in   1       MEM request, held until mem_done_o
//  mem_we_i     in   1       1=store, 0=load
//  mem_size_i   in   2       00=byte, 01=half, 10=word (11 treated as word)
//  mem_addr_i   in   32      load/store base address
//  mem_wdata_i  in   32      store data; byte k = bits [8k+7:8k]
//  mem_done_o   out  1       1-cycle pulse: access complete, mem_rdata_o valid for loads
//  mem_rdata_o  out  32      load data, zero-extended (mem stage sign-extends)
//  ram_addr_o   out  ADDR_W  RAM byte address
//  ram_wr_o     out  1       RAM write strobe
//  ram_dout_o   out  8       RAM write data
//  ram_din_i    in   8       RAM read data, valid the cycle after its address is presented
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (done pulses, ram_wr_o, ram_addr_o, ram_dout_o, if_inst_o, mem_rdata_o).
//  FSM states:
//   IDLE  sample requests; on grant latch owner, addr, size n (1/2/4), we, wdata; clear byte count; go BUSY.
//   BUSY  issue/collect bytes.
//   DONE  one cycle, done pulse to owner; then IDLE.
//  Arbitration: in IDLE, mem_req_i beats if_req_i when both are high. Requests are ignored outside IDLE.
//  Address/data inputs are sampled only at grant.
//  Timing, with grant at cycle G and n bytes, k=0..n-1 (all outputs registered):
//   Cycle G+1+k: ram_addr_o=addr+k (mod 2^ADDR_W), ram_wr_o=we, ram_dout_o=wdata byte k.
//   Read: ram_din_i in cycle G+2+k is byte k, placed in result bits [8k+7:8k]; upper unread bytes are 0.
//   Read: done pulse and data are valid in cycle G+2+n (word fetch: G+6).
//   Write: done pulse in cycle G+1+n (word store: G+5).
//   ram_wr_o=0 and ram_addr_o holds its last value in every cycle not issuing a byte.
//  Data outputs hold their value after done until the next completion of the same port.
//  Earliest next grant is the cycle after DONE, so the requester has the done cycle to drop or change its request.
//  Flush: if_flush_i=1 while IDLE suppresses an IF grant that cycle.
//   While BUSY with owner=IF, flush aborts: IDLE next cycle, no if_done_o, no further RAM cycles.
//   A flush in the DONE cycle of a fetch suppresses if_done_o.
//   Flush never affects a MEM-owned transaction.
//  Asynchronous reset mid-transaction aborts immediately: no done pulse, ram_wr_o=0.
//   A partially written store is not rolled back.
//  Unaligned addresses are legal; bytes wrap at 2^ADDR_W.
// TESTING
//  1. IF word read at 0x100, RAM bytes 13,00,50,00 -> addr 0x100..0x103 in G+1..G+4, if_done_o at G+6, if_inst_o=0x00500013.
//  2. MEM store byte 0xAB at 0x2000, wdata=0x123456AB -> one ram_wr_o cycle at G+1 with dout=0xAB, mem_done_o at G+2.
//  3. if_req_i and mem_req_i both rise in the same IDLE cycle -> MEM served first.
//     -> IF granted the cycle after mem_done_o's DONE cycle, with no idle gap beyond that.
//  4. if_flush_i at G+3 of a fetch -> no if_done_o, ram_addr_o stops advancing.
//     -> a pending MEM request is granted at G+4.
//  5. rst_n low at G+2 of a word store -> all outputs 0 asynchronously, state IDLE after release, no mem_done_o.
//  6. Half load at 0x1FFFF (ADDR_W=17), bytes 0x80,0x7F -> addresses 0x1FFFF then 0x00000, mem_rdata_o=0x00007F80.

Source files
------------

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter shared by instruction fetch (IF) and load/store (MEM).
// Each 1/2/4-byte access becomes consecutive little-endian byte cycles on the RAM.
module mem_arbiter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              if_flush_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          n_q, n_d;
    logic                we_q, we_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [31:0]         buf_q, buf_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_wr_q, ram_wr_d;
    logic [7:0]          ram_dout_q, ram_dout_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic [31:0]         if_inst_q, if_inst_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;

    logic [2:0]          cnt_nx;
    logic [1:0]          rd_idx;
    logic [1:0]          wr_idx;
    logic [31:0]         buf_nx;
    logic                xfer_last;
    logic [2:0]          mem_n;

    // Request address bits above the RAM width are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    // BUSY cycle cnt_q presents byte cnt_q and receives byte cnt_q-1 from the RAM.
    assign cnt_nx = cnt_q + 3'd1;
    assign rd_idx = cnt_q[1:0] - 2'd1;
    assign wr_idx = cnt_nx[1:0];

    always_comb begin
        case (mem_size_i)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        n_d         = n_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        buf_nx      = buf_q;
        xfer_last   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req_i) begin
                    state_d    = S_BUSY;
                    owner_d    = OWN_MEM;
                    addr_d     = mem_addr_i[ADDR_W-1:0];
                    n_d        = mem_n;
                    we_d       = mem_we_i;
                    wdata_d    = mem_wdata_i;
                    cnt_d      = 3'd0;
                    buf_d      = 32'd0;
                    ram_addr_d = mem_addr_i[ADDR_W-1:0];
                    ram_wr_d   = mem_we_i;
                    ram_dout_d = mem_wdata_i[7:0];
                end else if (if_req_i && !if_flush_i) begin
                    state_d    = S_BUSY;
                    owner_d    = OWN_IF;
                    addr_d     = if_addr_i[ADDR_W-1:0];
                    n_d        = 3'd4;
                    we_d       = 1'b0;
                    wdata_d    = 32'd0;
                    cnt_d      = 3'd0;
                    buf_d      = 32'd0;
                    ram_addr_d = if_addr_i[ADDR_W-1:0];
                end
            end

            S_BUSY: begin
                if (owner_q == OWN_IF && if_flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!we_q && cnt_q != 3'd0) begin
                        buf_nx[{rd_idx, 3'b000} +: 8] = ram_din_i;
                    end
                    buf_d = buf_nx;
                    cnt_d = cnt_nx;
                    if (cnt_nx < n_q) begin
                        ram_addr_d = addr_q + ADDR_W'(cnt_nx);
                        ram_wr_d   = we_q;
                        ram_dout_d = wdata_q[{wr_idx, 3'b000} +: 8];
                    end
                    // Stores finish once the last byte is issued; loads wait one more cycle for it.
                    xfer_last = we_q ? (cnt_q == n_q - 3'd1) : (cnt_q == n_q);
                    if (xfer_last) begin
                        state_d = S_DONE;
                        if (owner_q == OWN_IF) begin
                            if_done_d = 1'b1;
                            if_inst_d = buf_nx;
                        end else begin
                            mem_done_d = 1'b1;
                            if (!we_q) mem_rdata_d = buf_nx;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: async reset clears every register, so an aborted access leaves no strobe or pulse behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            n_q         <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            cnt_q       <= 3'd0;
            buf_q       <= 32'd0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= 8'd0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            n_q         <= n_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // A redirect arriving in the fetch's DONE cycle still cancels the pulse.
    assign if_done_o   = if_done_q & ~if_flush_i;
    assign if_inst_o   = if_inst_q;
    assign mem_done_o  = mem_done_q;
    assign mem_rdata_o = mem_rdata_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a byte-wide synchronous RAM model.
// Each task drives one scenario and checks cycle-exact RAM and done timing.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_done_o;
    logic [31:0] if_inst_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_done_o;
    logic [31:0] mem_rdata_o;
    logic [16:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:131071];

    mem_arbiter #(.ADDR_W(17)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_done_o   (if_done_o),
        .if_inst_o   (if_inst_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_size_i  (mem_size_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_done_o  (mem_done_o),
        .mem_rdata_o (mem_rdata_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wr_o    (ram_wr_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
        ram_din_i <= ram[ram_addr_o];
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({if_done_o, mem_done_o, ram_wr_o} !== 3'b000 || ram_addr_o !== 17'h0 ||
            ram_dout_o !== 8'h0 || if_inst_o !== 32'h0 || mem_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got done=%b/%b wr=%b addr=%h dout=%h inst=%h rdata=%h exp all zero",
                     if_done_o, mem_done_o, ram_wr_o, ram_addr_o, ram_dout_o, if_inst_o, mem_rdata_o);
        end
    endtask

    task automatic test_if_fetch();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ram_addr_o !== 17'(32'h100 + k) || ram_wr_o !== 1'b0) begin
                errors++;
                $display("FAIL fetch_addr k=%0d got addr=%h wr=%b exp addr=%h wr=0",
                         k, ram_addr_o, ram_wr_o, 17'(32'h100 + k));
            end
        end
        step();
        checks++;
        if (if_done_o !== 1'b0 || ram_addr_o !== 17'h103) begin
            errors++;
            $display("FAIL fetch_g5 got done=%b addr=%h exp done=0 addr=00103", if_done_o, ram_addr_o);
        end
        step();
        checks++;
        if (if_done_o !== 1'b1 || if_inst_o !== 32'h00500013) begin
            errors++;
            $display("FAIL fetch_done got done=%b inst=%h exp done=1 inst=00500013", if_done_o, if_inst_o);
        end
        if_req_i = 1'b0;
        step();
        checks++;
        if (if_done_o !== 1'b0 || if_inst_o !== 32'h00500013) begin
            errors++;
            $display("FAIL fetch_hold got done=%b inst=%h exp done=0 inst=00500013", if_done_o, if_inst_o);
        end
    endtask

    task automatic test_store_byte();
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b00;
        mem_addr_i = 32'h2000; mem_wdata_i = 32'h123456AB;
        step();
        checks++;
        if (ram_wr_o !== 1'b1 || ram_addr_o !== 17'h2000 || ram_dout_o !== 8'hAB || mem_done_o !== 1'b0) begin
            errors++;
            $display("FAIL store_issue got wr=%b addr=%h dout=%h done=%b exp wr=1 addr=02000 dout=ab done=0",
                     ram_wr_o, ram_addr_o, ram_dout_o, mem_done_o);
        end
        step();
        checks++;
        if (mem_done_o !== 1'b1 || ram_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL store_done got done=%b wr=%b exp done=1 wr=0", mem_done_o, ram_wr_o);
        end
        mem_req_i = 1'b0;
        step();
        checks++;
        if (ram[17'h2000] !== 8'hAB || mem_done_o !== 1'b0) begin
            errors++;
            $display("FAIL store_ram got ram=%h done=%b exp ram=ab done=0", ram[17'h2000], mem_done_o);
        end
    endtask

    task automatic test_back_to_back();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'h2000;
        step();
        checks++;
        if (ram_addr_o !== 17'h2000 || ram_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL arb_mem_first got addr=%h wr=%b exp addr=02000 wr=0", ram_addr_o, ram_wr_o);
        end
        step(2);
        checks++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h000000AB || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL arb_load_done got done=%b rdata=%h ifdone=%b exp done=1 rdata=000000ab ifdone=0",
                     mem_done_o, mem_rdata_o, if_done_o);
        end
        mem_req_i = 1'b0;
        step(2);
        checks++;
        if (ram_addr_o !== 17'h100) begin
            errors++;
            $display("FAIL arb_if_next got addr=%h exp addr=00100", ram_addr_o);
        end
        step(5);
        checks++;
        if (if_done_o !== 1'b1 || if_inst_o !== 32'h00500013) begin
            errors++;
            $display("FAIL arb_if_done got done=%b inst=%h exp done=1 inst=00500013", if_done_o, if_inst_o);
        end
        if_req_i = 1'b0;
        step();
    endtask

    task automatic test_flush_busy();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        step();
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b01;
        mem_addr_i = 32'h4000; mem_wdata_i = 32'h0000BEEF;
        step(2);
        checks++;
        if (ram_addr_o !== 17'h102) begin
            errors++;
            $display("FAIL flush_pre got addr=%h exp addr=00102", ram_addr_o);
        end
        if_flush_i = 1'b1;
        step();
        if_flush_i = 1'b0; if_req_i = 1'b0;
        checks++;
        if (ram_addr_o !== 17'h102 || ram_wr_o !== 1'b0 || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_stop got addr=%h wr=%b done=%b exp addr=00102 wr=0 done=0",
                     ram_addr_o, ram_wr_o, if_done_o);
        end
        step();
        checks++;
        if (ram_addr_o !== 17'h4000 || ram_wr_o !== 1'b1 || ram_dout_o !== 8'hEF || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_mem0 got addr=%h wr=%b dout=%h ifdone=%b exp addr=04000 wr=1 dout=ef ifdone=0",
                     ram_addr_o, ram_wr_o, ram_dout_o, if_done_o);
        end
        step();
        checks++;
        if (ram_addr_o !== 17'h4001 || ram_wr_o !== 1'b1 || ram_dout_o !== 8'hBE || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_mem1 got addr=%h wr=%b dout=%h ifdone=%b exp addr=04001 wr=1 dout=be ifdone=0",
                     ram_addr_o, ram_wr_o, ram_dout_o, if_done_o);
        end
        step();
        checks++;
        if (mem_done_o !== 1'b1 || if_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_mem_done got done=%b ifdone=%b wr=%b exp done=1 ifdone=0 wr=0",
                     mem_done_o, if_done_o, ram_wr_o);
        end
        mem_req_i = 1'b0;
        step();
    endtask

    task automatic test_flush_idle_done();
        if_req_i = 1'b1; if_addr_i = 32'h100; if_flush_i = 1'b1;
        step();
        if_flush_i = 1'b0;
        checks++;
        if (ram_addr_o !== 17'h4001 || ram_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle got addr=%h wr=%b exp addr=04001 wr=0", ram_addr_o, ram_wr_o);
        end
        step(6);
        if_flush_i = 1'b1;
        #1;
        checks++;
        if (if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_cycle got done=%b exp done=0", if_done_o);
        end
        step();
        if_flush_i = 1'b0; if_req_i = 1'b0;
        checks++;
        if (if_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_after got done=%b wr=%b exp done=0 wr=0", if_done_o, ram_wr_o);
        end
        step();
    endtask

    task automatic test_reset_midstore();
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10;
        mem_addr_i = 32'h5000; mem_wdata_i = 32'h11223344;
        step();
        checks++;
        if (ram_wr_o !== 1'b1 || ram_dout_o !== 8'h44 || ram_addr_o !== 17'h5000) begin
            errors++;
            $display("FAIL rst_pre got wr=%b dout=%h addr=%h exp wr=1 dout=44 addr=05000",
                     ram_wr_o, ram_dout_o, ram_addr_o);
        end
        step();
        rst_n = 1'b0; mem_req_i = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (mem_done_o !== 1'b0 || ram_wr_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_nodone c=%0d got done=%b wr=%b exp done=0 wr=0", c, mem_done_o, ram_wr_o);
            end
        end
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'h5000;
        step(3);
        checks++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h00000044) begin
            errors++;
            $display("FAIL rst_partial got done=%b rdata=%h exp done=1 rdata=00000044", mem_done_o, mem_rdata_o);
        end
        mem_req_i = 1'b0;
        step();
    endtask

    task automatic test_wrap_half();
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b01; mem_addr_i = 32'h1FFFF;
        step();
        checks++;
        if (ram_addr_o !== 17'h1FFFF) begin
            errors++;
            $display("FAIL wrap_a0 got addr=%h exp addr=1ffff", ram_addr_o);
        end
        step();
        checks++;
        if (ram_addr_o !== 17'h00000) begin
            errors++;
            $display("FAIL wrap_a1 got addr=%h exp addr=00000", ram_addr_o);
        end
        step(2);
        checks++;
        if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h00007F80) begin
            errors++;
            $display("FAIL wrap_data got done=%b rdata=%h exp done=1 rdata=00007f80", mem_done_o, mem_rdata_o);
        end
        mem_req_i = 1'b0;
        step();
    endtask

    initial begin
        for (int a = 0; a < 131072; a++) ram[a] = 8'h00;
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h00;
        ram[17'h102] = 8'h50; ram[17'h103] = 8'h00;
        ram[17'h1FFFF] = 8'h80; ram[17'h00000] = 8'h7F;
        rst_n = 1'b0;
        if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = 2'b00;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_if_fetch();
        test_store_byte();
        test_back_to_back();
        test_flush_busy();
        test_flush_idle_done();
        test_reset_midstore();
        test_wrap_half();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
